// File: rtl/vga_timing_gen_if.sv
// Pixel-stream bundle between the VGA timing generator and the game/colour logic.
// pix_en is the valid strobe for hCount/vCount. The stream has no ready and the sink cannot stall it.
interface vga_timing_gen_if;
    logic [11:0] rgb_in;
    logic        pix_en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic        frame_tick;
    logic [11:0] vga_rgb;
    logic        hSync;
    logic        vSync;
    logic [7:0]  frame_count;

    modport master (
        input  rgb_in,
        output pix_en, hCount, vCount, bright, frame_tick,
        output vga_rgb, hSync, vSync, frame_count
    );

    modport slave (
        output rgb_in,
        input  pix_en, hCount, vCount, bright, frame_tick,
        input  vga_rgb, hSync, vSync, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480 VGA timing source: pixel-enable divider, h/v counters, registered colour/sync and frame tick.
// Optional 8-bit frame counter is built when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0]       V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0]       H_ACT_S   = 10'(H_ACT_START);
    localparam logic [9:0]       H_ACT_E   = 10'(H_ACT_END);
    localparam logic [9:0]       V_ACT_S   = 10'(V_ACT_START);
    localparam logic [9:0]       V_ACT_E   = 10'(V_ACT_END);
    localparam logic [9:0]       V_TICK_LN = 10'(V_ACT_END - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             pix_en;
    logic             h_last;
    logic             v_last;
    logic             frame_end;
    logic             bright;
    logic             hs_raw;
    logic             vs_raw;
    logic [11:0]      rgb_q;
    logic             hs_q;
    logic             vs_q;
    logic             tick_q;
    logic [7:0]       frame_cnt;

    assign pix_en    = (div_cnt == DIV_LAST);
    assign h_last    = (h_cnt == H_LAST);
    assign v_last    = (v_cnt == V_LAST);
    assign frame_end = pix_en && h_last && (v_cnt == V_TICK_LN);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // The vertical counter steps on the same pix_en as the horizontal wrap,
    // so (H_TOTAL-1, V_TOTAL-1) goes to (0,0) in one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        bright = 1'b0;
        hs_raw = 1'b1;
        vs_raw = 1'b1;
        bright = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E) &&
                 (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
        hs_raw = (h_cnt >= H_SYNC_W);
        vs_raw = (v_cnt >= V_SYNC_W);
    end

    // Colour and both syncs are captured together so they stay aligned at the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            tick_q <= frame_end;
            if (pix_en) begin
                rgb_q <= bright ? vga.rgb_in : 12'h000;
                hs_q  <= hs_raw;
                vs_q  <= vs_raw;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    assign frame_cnt = 8'd0;
`endif

    assign vga.pix_en      = pix_en;
    assign vga.hCount      = h_cnt;
    assign vga.vCount      = v_cnt;
    assign vga.bright      = bright;
    assign vga.frame_tick  = tick_q;
    assign vga.vga_rgb     = rgb_q;
    assign vga.hSync       = hs_q;
    assign vga.vSync       = vs_q;
    assign vga.frame_count = frame_cnt;
endmodule
